// File: rtl/serial_tx32_if.sv
// Word-in / bit-out handshake bundle for serial_tx32.
// The slave modport is the transmitter side. The master modport is the word producer side.
interface serial_tx32_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  tx_serial;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_serial,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_serial,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/serial_tx32.sv
// Bit-serial transmitter: start(0), DATA_WIDTH bits LSB-first, optional parity, stop(1).
// The parity bit is present only when SERIAL_TX_PARITY_EN is defined.
module serial_tx32 #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input logic           clk,
  input logic           reset,
  serial_tx32_if.slave  bus
);

  localparam int unsigned DivW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH) + 1;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  serial_q, serial_d;
  logic                  done_q, done_d;
  logic                  ready;
  logic                  bit_end;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign ready   = (state_q == StIdle) & ~reset;
  assign bit_end = (div_q == DivW'(CLKS_PER_BIT - 1));

  // serial_d carries the level of the state being entered, so the line moves with the state.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        div_d    = '0;
        bit_d    = '0;
        if (bus.tx_valid && ready) begin
          shift_d  = bus.tx_data;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = (^bus.tx_data) ^ PARITY_ODD;
`endif
          serial_d = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          div_d    = '0;
          serial_d = shift_q[0];
          state_d  = StData;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          div_d = '0;
          if (bit_q == BitW'(DATA_WIDTH - 1)) begin
            bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = StParity;
`else
            serial_d = 1'b1;
            state_d  = StStop;
`endif
          end else begin
            bit_d    = bit_q + BitW'(1);
            shift_d  = shift_q >> 1;
            serial_d = shift_d[0];
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          div_d    = '0;
          serial_d = 1'b1;
          state_d  = StStop;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          div_d    = '0;
          serial_d = 1'b1;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: begin
        serial_d = 1'b1;
        div_d    = '0;
        bit_d    = '0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.tx_ready  = ready;
  assign bus.tx_serial = serial_q;
  assign bus.tx_busy   = (state_q != StIdle);
  assign bus.tx_done   = done_q;

endmodule

// File: tb/tb_serial_tx32.sv
// Bench for serial_tx32: an even-parity and an odd-parity instance share stimulus, and each
// captured frame is compared against a bit-list model built from the frame format.
module tb_serial_tx32;

  localparam int DW     = 32;
  localparam int CPB    = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PEN    = 1;
`else
  localparam int PEN    = 0;
`endif
  localparam int FRAME  = (DW + 2 + PEN) * CPB;
  localparam int MaxLen = 160;

  logic          clk;
  logic          reset;
  logic          valid;
  logic [DW-1:0] data;
  int            n_checks = 0;
  int            n_fail   = 0;

  serial_tx32_if #(.DATA_WIDTH(DW)) bus0 ();
  serial_tx32_if #(.DATA_WIDTH(DW)) bus1 ();

  assign bus0.tx_valid = valid;
  assign bus0.tx_data  = data;
  assign bus1.tx_valid = valid;
  assign bus1.tx_data  = data;

  serial_tx32 #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  serial_tx32 #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [MaxLen-1:0] obs,
                       input logic [MaxLen-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level per cycle after accept: bit k of the result is the level in cycle k.
  function automatic logic [MaxLen-1:0] model_frame(input logic [DW-1:0] w, input bit odd);
    bit                seq[$];
    logic [MaxLen-1:0] f;
    f = '0;
    seq.push_back(1'b0);
    for (int i = 0; i < DW; i++) seq.push_back(w[i]);
    if (PEN != 0) seq.push_back((($countones(w) % 2) != 0) ^ odd);
    seq.push_back(1'b1);
    for (int s = 0; s < seq.size(); s++)
      for (int c = 0; c < CPB; c++) f[s*CPB+c] = seq[s];
    return f;
  endfunction

  task automatic wait_ready(input string tag);
    for (int t = 0; t < 300 && !bus0.tx_ready; t++) @(negedge clk);
    check(tag, bus0.tx_ready, 1'b1);
  endtask

  // Called at a negedge. If pre_accepted, valid/data already present w for the next edge.
  task automatic run_frame(input logic [DW-1:0] w, input int inject_at, input bit hold,
                           input logic [DW-1:0] next_w, input bit pre_accepted);
    logic [MaxLen-1:0] cap0, cap1;
    int                spurious;
    cap0     = '0;
    cap1     = '0;
    spurious = 0;
    if (!pre_accepted) begin
      wait_ready("ready_before_send");
      valid = 1'b1;
      data  = w;
    end
    @(posedge clk);
    #1;
    valid = hold;
    data  = hold ? next_w : $urandom;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      cap0[k] = bus0.tx_serial;
      cap1[k] = bus1.tx_serial;
      if (bus0.tx_done || bus1.tx_done) spurious++;
      if (k == 0) begin
        check("busy_in_frame", bus0.tx_busy, 1'b1);
        check("ready_in_frame", bus0.tx_ready, 1'b0);
      end
      if (k == inject_at) begin
        valid = 1'b1;
        data  = 32'hA5A5_A5A5;
      end else if (k == inject_at + 1) begin
        valid = hold;
        data  = hold ? next_w : $urandom;
      end
    end
    @(negedge clk);
    check("done_pulse", {bus1.tx_done, bus0.tx_done}, 2'b11);
    check("ready_in_done", bus0.tx_ready, 1'b1);
    check("line_in_done", bus0.tx_serial, 1'b1);
    check("early_done", spurious, 0);
    check("frame_even", cap0, model_frame(w, 1'b0));
    check("frame_odd", cap1, model_frame(w, 1'b1));
  endtask

  initial begin
    int seen_done;
    int seen_low;
    logic [DW-1:0] w;
    reset = 1'b1;
    valid = 1'b0;
    data  = '0;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_serial", bus0.tx_serial, 1'b1);
      check("rst_busy", bus0.tx_busy, 1'b0);
      check("rst_done", bus0.tx_done, 1'b0);
    end
    reset = 1'b0;
    #1;
    check("rst_ready", bus0.tx_ready, 1'b1);
    @(negedge clk);

    run_frame(32'h0000_0001, -5, 1'b0, '0, 1'b0);
    run_frame(32'hFFFF_FFFF, -5, 1'b0, '0, 1'b0);
    run_frame(32'h0000_0000, -5, 1'b0, '0, 1'b0);
    run_frame($urandom, 60, 1'b0, '0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      w = $urandom;
      run_frame(w, int'($urandom_range(5, FRAME - 10)), 1'b0, '0, 1'b0);
    end

    // Back-to-back with tx_valid held: second word goes in on the tx_done cycle.
    w = $urandom;
    run_frame($urandom, -5, 1'b1, w, 1'b0);
    run_frame(w, -5, 1'b0, '0, 1'b1);

    // Reset 50 cycles into a frame.
    wait_ready("ready_before_abort");
    valid = 1'b1;
    data  = $urandom;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (50) @(negedge clk);
    check("busy_before_abort", bus0.tx_busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_serial", bus0.tx_serial, 1'b1);
    check("abort_busy", bus0.tx_busy, 1'b0);
    check("abort_done", bus0.tx_done, 1'b0);
    reset = 1'b0;
    seen_done = 0;
    seen_low  = 0;
    for (int k = 0; k < FRAME + 10; k++) begin
      @(negedge clk);
      if (bus0.tx_done || bus1.tx_done) seen_done++;
      if (!bus0.tx_serial) seen_low++;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_line_high", seen_low, 0);
    check("abort_ready", bus0.tx_ready, 1'b1);

    run_frame($urandom, -5, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
